// File: rtl/nios2core_nios2_e_cpu_ocimem_master_pkg.sv
// Shared definitions for the ocimem Avalon-MM master: FSM encoding,
// jdo payload field positions and fixed bus constants.
package nios2core_nios2_e_cpu_ocimem_master_pkg;

   // FSM state encoding. Kept as plain constants so the encoding stays
   // readable in waveforms and portable to older tool flows.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;

   // jdo payload layout.
   localparam int unsigned JDO_W       = 38;
   localparam int unsigned JDO_RDNOW   = 36;  // ocimem_a: start a read now
   localparam int unsigned JDO_AUTOINC = 35;  // ocimem_a: bump address after each access
   localparam int unsigned DATA_W      = 32;

   // Every access is a full word.
   localparam logic [3:0] AVM_BYTEENABLE = 4'hF;

   // Width of the stall counter; large enough for the biggest legal timeout.
   localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/nios2core_nios2_e_cpu_ocimem_timeout.sv
// Stall counter for one Avalon access. Cleared while the master is idle,
// advanced once per stalled cycle; expired_o flags the stall that reaches
// the TIMEOUT_CYC limit so the master can abort on that same edge.
module nios2core_nios2_e_cpu_ocimem_timeout
   import nios2core_nios2_e_cpu_ocimem_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   // The counter holds the number of stalls already seen, so the
   // TIMEOUT_CYC-th stall is the one observed while it reads TIMEOUT_CYC-1.
   localparam logic [TMO_CNT_W-1:0] LAST_STALL = TMO_CNT_W'(TIMEOUT_CYC - 1);

   logic [TMO_CNT_W-1:0] cnt_q;
   logic [TMO_CNT_W-1:0] cnt_d;

   assign expired_o = en_i && (cnt_q == LAST_STALL);

   // Next count: clear has priority, saturate once expired.
   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nios2core_nios2_e_cpu_ocimem_master.sv
// JTAG debug memory master. Converts ocimem take_action strobes and the
// jdo payload into single-word Avalon-MM reads and writes, and reports the
// read data and command status back through MonDReg, monitor_ready and
// monitor_error. Only one access is in flight at a time; commands are
// accepted in IDLE only, anything arriving while busy is flagged.
module nios2core_nios2_e_cpu_ocimem_master
   import nios2core_nios2_e_cpu_ocimem_master_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [JDO_W-1:0]    jdo,
   input  logic                take_action_ocimem_a,
   input  logic                take_no_action_ocimem_a,
   input  logic                take_action_ocimem_b,
   output logic [DATA_W-1:0]   MonDReg,
   output logic                monitor_ready,
   output logic                monitor_error,
   output logic [ADDR_W+1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [3:0]          avm_byteenable,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_waitrequest
);

   // Architectural state.
   logic [1:0]        state_q,   state_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic              autoinc_q, autoinc_d;
   logic [DATA_W-1:0] mondreg_q, mondreg_d;
   logic              ready_q,   ready_d;
   logic              error_q,   error_d;
   logic              read_q,    read_d;
   logic              write_q,   write_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;

   // Handshake qualifiers for the access in flight.
   logic busy;
   logic stall;
   logic done;
   logic timed_out;

   // The status-poll strobe and the spare jdo bits carry no function here.
   logic unused_inputs;
   assign unused_inputs = ^{take_no_action_ocimem_a, jdo[JDO_W-1], jdo[JDO_AUTOINC-1:DATA_W]};

   assign busy  = (state_q == ST_RD) || (state_q == ST_WR);
   assign stall = busy && avm_waitrequest;
   assign done  = busy && !avm_waitrequest;

   nios2core_nios2_e_cpu_ocimem_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (!busy),
      .en_i      (stall),
      .expired_o (timed_out)
   );

   // Command decode and access sequencing.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      autoinc_d = autoinc_q;
      mondreg_d = mondreg_q;
      ready_d   = ready_q;
      error_d   = error_q;
      read_d    = read_q;
      write_d   = write_q;
      wdata_d   = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (take_action_ocimem_a) begin
               // ocimem_a wins a collision; the dropped ocimem_b is reported.
               addr_d    = jdo[ADDR_W-1:0];
               autoinc_d = jdo[JDO_AUTOINC];
               error_d   = take_action_ocimem_b;
               if (jdo[JDO_RDNOW]) begin
                  ready_d = 1'b0;
                  read_d  = 1'b1;
                  state_d = ST_RD;
               end
            end else if (take_action_ocimem_b) begin
               wdata_d = jdo[DATA_W-1:0];
               ready_d = 1'b0;
               write_d = 1'b1;
               state_d = ST_WR;
            end
         end

         ST_RD, ST_WR: begin
            if (take_action_ocimem_a || take_action_ocimem_b) begin
               error_d = 1'b1;
            end
            if (done) begin
               if (state_q == ST_RD) begin
                  mondreg_d = avm_readdata;
               end
               addr_d  = addr_q + ADDR_W'(autoinc_q);
               read_d  = 1'b0;
               write_d = 1'b0;
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else if (timed_out) begin
               // Abort: no data captured, address left where it was.
               read_d  = 1'b0;
               write_d = 1'b0;
               ready_d = 1'b1;
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: begin
            // Unreachable encoding: fall back to a quiet idle.
            read_d  = 1'b0;
            write_d = 1'b0;
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset also withdraws any request on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         autoinc_q <= 1'b0;
         mondreg_q <= '0;
         ready_q   <= 1'b1;
         error_q   <= 1'b0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         autoinc_q <= autoinc_d;
         mondreg_q <= mondreg_d;
         ready_q   <= ready_d;
         error_q   <= error_d;
         read_q    <= read_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
      end
   end

   assign MonDReg        = mondreg_q;
   assign monitor_ready  = ready_q;
   assign monitor_error  = error_q;
   assign avm_address    = {addr_q, 2'b00};
   assign avm_read       = read_q;
   assign avm_write      = write_q;
   assign avm_writedata  = wdata_q;
   assign avm_byteenable = AVM_BYTEENABLE;

endmodule

// File: tb/tb_nios2core_nios2_e_cpu_ocimem_master.sv
// Directed bench for the ocimem Avalon master: a vector table for the
// single-cycle command/response behaviour, then hand-written sequences for
// timeout, busy collisions and reset during an access.
module tb_nios2core_nios2_e_cpu_ocimem_master;

   localparam int unsigned ADDR_W      = 10;
   localparam int unsigned TIMEOUT_CYC = 255;

   localparam logic [37:0] RD = 38'(1) << 36;
   localparam logic [37:0] AI = 38'(1) << 35;

   logic              clk = 1'b0;
   logic              reset;
   logic [37:0]       jdo;
   logic              ta_a, tna_a, ta_b;
   logic [31:0]       mondreg;
   logic              mon_ready, mon_error;
   logic [ADDR_W+1:0] avm_address;
   logic              avm_read, avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic [31:0]       avm_readdata;
   logic              avm_waitrequest;

   int checks = 0;
   int errors = 0;

   nios2core_nios2_e_cpu_ocimem_master #(
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (ta_a),
      .take_no_action_ocimem_a (tna_a),
      .take_action_ocimem_b    (ta_b),
      .MonDReg                 (mondreg),
      .monitor_ready           (mon_ready),
      .monitor_error           (mon_error),
      .avm_address             (avm_address),
      .avm_read                (avm_read),
      .avm_write               (avm_write),
      .avm_writedata           (avm_writedata),
      .avm_byteenable          (avm_byteenable),
      .avm_readdata            (avm_readdata),
      .avm_waitrequest         (avm_waitrequest)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        a, na, b;
      logic [37:0] jdo;
      logic        wreq;
      logic [31:0] rdata;
      logic        e_read, e_write, e_ready, e_error;
      logic [11:0] e_addr;
      logic [31:0] e_mond, e_wdata;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic a, na, b, input logic [37:0] j,
                               input logic w, input logic [31:0] rd,
                               input logic er, ew, ey, ee, input logic [11:0] ea,
                               input logic [31:0] em, ewd);
      vec_t v;
      v.a = a; v.na = na; v.b = b; v.jdo = j; v.wreq = w; v.rdata = rd;
      v.e_read = er; v.e_write = ew; v.e_ready = ey; v.e_error = ee;
      v.e_addr = ea; v.e_mond = em; v.e_wdata = ewd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic er, ew, ey, ee,
                            input logic [11:0] ea, input logic [31:0] em, ewd);
      check({tag, " avm_read"},      32'(avm_read),    32'(er));
      check({tag, " avm_write"},     32'(avm_write),   32'(ew));
      check({tag, " ready"},         32'(mon_ready),   32'(ey));
      check({tag, " error"},         32'(mon_error),   32'(ee));
      check({tag, " avm_address"},   32'(avm_address), 32'(ea));
      check({tag, " MonDReg"},       mondreg,          em);
      check({tag, " avm_writedata"}, avm_writedata,    ewd);
   endtask

   // Global safety net so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      //            a  na b  jdo               wr rdata        rd wr rdy err addr    MonDReg       wdata
      vecs[0]  = mk(1, 0, 0, RD | 38'h010,      0, 32'hDEADBEEF, 1, 0, 0, 0, 12'h040, 32'h0,        32'h0);
      vecs[1]  = mk(0, 0, 0, 38'h0,             0, 32'hDEADBEEF, 0, 0, 1, 0, 12'h040, 32'hDEADBEEF, 32'h0);
      vecs[2]  = mk(0, 1, 0, RD | 38'h3FF,      0, 32'h0,        0, 0, 1, 0, 12'h040, 32'hDEADBEEF, 32'h0);
      vecs[3]  = mk(1, 0, 0, AI | 38'h3FF,      0, 32'h0,        0, 0, 1, 0, 12'hFFC, 32'hDEADBEEF, 32'h0);
      vecs[4]  = mk(0, 0, 1, 38'h12345678,      0, 32'h0,        0, 1, 0, 0, 12'hFFC, 32'hDEADBEEF, 32'h12345678);
      vecs[5]  = mk(0, 0, 0, 38'h0,             0, 32'h0,        0, 0, 1, 0, 12'h000, 32'hDEADBEEF, 32'h12345678);
      vecs[6]  = mk(0, 0, 1, 38'h12345678,      0, 32'h0,        0, 1, 0, 0, 12'h000, 32'hDEADBEEF, 32'h12345678);
      vecs[7]  = mk(0, 0, 0, 38'h0,             0, 32'h0,        0, 0, 1, 0, 12'h004, 32'hDEADBEEF, 32'h12345678);
      vecs[8]  = mk(1, 0, 1, RD | 38'h020,      0, 32'hCAFEF00D, 1, 0, 0, 1, 12'h080, 32'hDEADBEEF, 32'h12345678);
      vecs[9]  = mk(0, 0, 0, 38'h0,             0, 32'hCAFEF00D, 0, 0, 1, 1, 12'h080, 32'hCAFEF00D, 32'h12345678);
      vecs[10] = mk(1, 0, 0, 38'h005,           0, 32'h0,        0, 0, 1, 0, 12'h014, 32'hCAFEF00D, 32'h12345678);
      vecs[11] = mk(1, 0, 0, RD | AI | 38'h001, 1, 32'h0,        1, 0, 0, 0, 12'h004, 32'hCAFEF00D, 32'h12345678);
      vecs[12] = mk(0, 0, 0, 38'h0,             1, 32'h0,        1, 0, 0, 0, 12'h004, 32'hCAFEF00D, 32'h12345678);
      vecs[13] = mk(0, 0, 0, 38'h0,             0, 32'h0BADF00D, 0, 0, 1, 0, 12'h008, 32'h0BADF00D, 32'h12345678);

      // Reset state.
      reset = 1'b1; jdo = '0; idle_in();
      avm_readdata = '0; avm_waitrequest = 1'b0;
      repeat (3) cycle();
      check_all("reset", 0, 0, 1, 0, 12'h000, 32'h0, 32'h0);
      check("reset byteenable", 32'(avm_byteenable), 32'hF);
      reset = 1'b0;
      cycle();

      // Table: inputs held for one cycle, outputs compared after the edge.
      for (int i = 0; i < 14; i++) begin
         ta_a = vecs[i].a; tna_a = vecs[i].na; ta_b = vecs[i].b;
         jdo = vecs[i].jdo;
         avm_waitrequest = vecs[i].wreq;
         avm_readdata = vecs[i].rdata;
         cycle();
         check_all($sformatf("v%0d", i), vecs[i].e_read, vecs[i].e_write, vecs[i].e_ready,
                   vecs[i].e_error, vecs[i].e_addr, vecs[i].e_mond, vecs[i].e_wdata);
      end
      idle_in();

      // Timeout: read with the slave stalling well past the limit.
      avm_waitrequest = 1'b1;
      avm_readdata = 32'h77777777;
      ta_a = 1'b1; jdo = RD | AI | 38'h010;
      cycle();
      idle_in();
      check("tmo start read", 32'(avm_read), 32'h1);
      n = 0;
      while (avm_read && n < 300) begin
         cycle();
         n++;
      end
      check("tmo stall count", 32'(n), 32'(TIMEOUT_CYC));
      check_all("tmo end", 0, 0, 1, 1, 12'h040, 32'h0BADF00D, 32'h12345678);
      repeat (300 - TIMEOUT_CYC) cycle();
      check("tmo no re-request", 32'(avm_read), 32'h0);
      avm_waitrequest = 1'b0;
      cycle();

      // Strobes while a read is stalled.
      avm_waitrequest = 1'b1;
      ta_a = 1'b1; jdo = RD | 38'h020;
      cycle();
      idle_in();
      check_all("busy start", 1, 0, 0, 0, 12'h080, 32'h0BADF00D, 32'h12345678);
      tna_a = 1'b1; jdo = RD | AI | 38'h3FF;
      cycle();
      idle_in();
      check_all("busy noaction", 1, 0, 0, 0, 12'h080, 32'h0BADF00D, 32'h12345678);
      ta_b = 1'b1; jdo = 38'h55555555;
      cycle();
      idle_in();
      check_all("busy ocimem_b", 1, 0, 0, 1, 12'h080, 32'h0BADF00D, 32'h12345678);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check($sformatf("busy no write %0d", k), 32'(avm_write), 32'h0);
      end
      avm_waitrequest = 1'b0; avm_readdata = 32'h11112222;
      cycle();
      check_all("busy done", 0, 0, 1, 1, 12'h080, 32'h11112222, 32'h12345678);
      ta_a = 1'b1; jdo = 38'h000;
      cycle();
      idle_in();
      check_all("error cleared", 0, 0, 1, 0, 12'h000, 32'h11112222, 32'h12345678);

      // Reset in the middle of a stalled write.
      ta_a = 1'b1; jdo = 38'h123;
      cycle();
      idle_in();
      avm_waitrequest = 1'b1;
      ta_b = 1'b1; jdo = 38'h9ABCDEF0;
      cycle();
      idle_in();
      check_all("wr stalled", 0, 1, 0, 0, 12'h48C, 32'h11112222, 32'h9ABCDEF0);
      ta_a = 1'b1; jdo = RD | 38'h001;
      cycle();
      idle_in();
      check_all("wr busy ocimem_a", 0, 1, 0, 1, 12'h48C, 32'h11112222, 32'h9ABCDEF0);
      reset = 1'b1;
      cycle();
      check_all("mid reset", 0, 0, 1, 0, 12'h000, 32'h0, 32'h0);
      reset = 1'b0;
      avm_waitrequest = 1'b0;
      repeat (2) cycle();
      check_all("after reset", 0, 0, 1, 0, 12'h000, 32'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
